// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared constants and helpers for the data-memory responder:
//             FSM state encoding, word size and the access error check.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states (2-bit encoding)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int unsigned WORD_BYTES = 4;

    // An access is rejected when the byte address is not word aligned or the
    // word address falls past the end of storage.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned depth_words);
        logic [31:0] word_addr;
        word_addr = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_addr >= depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_word_ram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_word_ram
//  Purpose  : Word-addressed storage with synchronous write and registered
//             read; reset clears every word and the read register.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_word_ram #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Clear-on-reset storage; read register samples the addressed word every
    // cycle (old data on a same-cycle write).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= 32'd0;
            end
            rdata_q <= 32'd0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder with a single outstanding request,
//             LATENCY wait states and misaligned/out-of-range error flagging.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    // Only used when LATENCY > 0, so the LATENCY == 0 wrap is never loaded.
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             enter_resp;
    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;
    logic             rsp_err;

    // State register plus captured request and wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: capture on accept, count down wait states, release on
    // response handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The memory access happens on the edge entering RESP. With zero latency
    // that edge is also the accept edge, so the live request must be used.
    always_comb begin
        acc_write  = write_q;
        acc_addr   = addr_q;
        acc_wdata  = wdata_q;
        if (state_q == S_IDLE) begin
            acc_write = req_write_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        ram_we     = enter_resp && acc_write && !addr_err(acc_addr, DEPTH_WORDS);
        ram_idx    = acc_addr[IDX_W+1:2];
    end

    dmem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    // Outputs: handshake flags from state; load data only for error-free
    // loads, otherwise zero. Storage is untouched in RESP so data holds.
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_err     = addr_err(addr_q, DEPTH_WORDS);
        rsp_err_o   = rsp_valid_o && rsp_err;
        rsp_rdata_o = 32'd0;
        if (rsp_valid_o && !write_q && !rsp_err) begin
            rsp_rdata_o = ram_rdata;
        end
    end

endmodule
`default_nettype wire
